// File: rtl/pc_next_pkg.sv
// Shared types and constants for the fetch-stage next-PC unit.
package pc_next_pkg;

    // Handler state machine: normal fetch, or executing the interrupt handler
    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } pc_state_t;

    // Default PC after reset and default interrupt vector
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h8000_0180;

    // Candidate next-PC source positions within the packed source bus
    localparam int SRC_SEQ = 0;
    localparam int SRC_BR  = 1;
    localparam int SRC_J   = 2;
    localparam int SRC_JR  = 3;
    localparam int SRC_ALT = 4;

    // Default number of candidate sources and matching select width
    localparam int DEFAULT_NUM_SRC = 5;
    localparam int DEFAULT_SEL_W   = 3;

endpackage

// File: rtl/pc_next_unit_mux.sv
// Combinational NUM_SRC:1 next-PC source mux. A select beyond the last
// source clamps to the last source rather than producing an undefined value.
module pc_src_mux #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3
) (
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    output logic [WIDTH-1:0]         mux_pc
);

    // Start from the clamp value, then override with the matching slice
    always_comb begin
        mux_pc = src_data[(NUM_SRC-1)*WIDTH +: WIDTH];
        for (int i = 0; i < NUM_SRC - 1; i++) begin
            if (int'(sel) == i) begin
                mux_pc = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_next_unit.sv
// Program-counter register and next-PC selection for the fetch stage,
// including interrupt entry, EPC capture and ERET return.
module pc_next_unit
    import pc_next_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter int               NUM_SRC    = DEFAULT_NUM_SRC,
    parameter int               SEL_W      = DEFAULT_SEL_W,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
    parameter logic [WIDTH-1:0] HANDLER_PC = WIDTH'(DEFAULT_HANDLER_PC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     int_req,
    input  logic                     eret,
    output logic [WIDTH-1:0]         pc_out,
    output logic [WIDTH-1:0]         epc,
    output logic                     in_handler,
    output logic                     int_ack
);

    pc_state_t        state;
    pc_state_t        state_next;
    logic [WIDTH-1:0] mux_pc;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] epc_next;
    logic             pending;
    logic             pending_next;
    logic             ack_next;
    logic             take_int;

    pc_src_mux #(
        .WIDTH   (WIDTH),
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_src_mux (
        .src_data (src_data),
        .sel      (sel),
        .mux_pc   (mux_pc)
    );

    // Next-state decision: stall beats interrupt entry, which beats ERET,
    // which beats the normal selected fall-through/branch/jump target
    always_comb begin
        state_next   = state;
        pc_next      = pc_out;
        epc_next     = epc;
        pending_next = pending | int_req;
        ack_next     = 1'b0;
        take_int     = 1'b0;

        if (!stall) begin
            case (state)
                RUN: begin
                    if (pending || int_req) begin
                        // A request already pending is served now; a new
                        // request on this same cycle must survive for later.
                        // A fresh request with nothing pending is the one
                        // being served, so nothing stays latched.
                        take_int     = 1'b1;
                        epc_next     = mux_pc;
                        pc_next      = HANDLER_PC;
                        state_next   = HANDLER;
                        pending_next = pending & int_req;
                        ack_next     = 1'b1;
                    end else begin
                        pc_next = mux_pc;
                    end
                end
                HANDLER: begin
                    if (eret) begin
                        pc_next    = epc;
                        state_next = RUN;
                    end else begin
                        pc_next = mux_pc;
                    end
                end
                default: begin
                    state_next = RUN;
                    pc_next    = mux_pc;
                end
            endcase
        end
    end

    // State, PC, EPC, pending latch and acknowledge pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            pc_out  <= RESET_PC;
            epc     <= '0;
            pending <= 1'b0;
            int_ack <= 1'b0;
        end else begin
            state   <= state_next;
            pc_out  <= pc_next;
            epc     <= epc_next;
            pending <= pending_next;
            int_ack <= ack_next;
        end
    end

    assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed self-checking bench for pc_next_unit.
module tb_pc_next_unit;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = 3;
    localparam logic [31:0] HPC = 32'h8000_0180;

    logic                     clk;
    logic                     rst;
    logic                     stall;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [SEL_W-1:0]         sel;
    logic                     int_req;
    logic                     eret;
    logic [WIDTH-1:0]         pc_out;
    logic [WIDTH-1:0]         epc;
    logic                     in_handler;
    logic                     int_ack;

    int checks;
    int failures;

    pc_next_unit #(
        .WIDTH      (WIDTH),
        .NUM_SRC    (NUM_SRC),
        .SEL_W      (SEL_W),
        .RESET_PC   (32'h0000_0000),
        .HANDLER_PC (HPC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .src_data   (src_data),
        .sel        (sel),
        .int_req    (int_req),
        .eret       (eret),
        .pc_out     (pc_out),
        .epc        (epc),
        .in_handler (in_handler),
        .int_ack    (int_ack)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock once, and settle past the edge
    task automatic applyStimulus(input logic r, input logic st, input logic [SEL_W-1:0] s,
                                 input logic irq, input logic er);
        rst     = r;
        stall   = st;
        sel     = s;
        int_req = irq;
        eret    = er;
        @(posedge clk);
        #1;
    endtask

    logic [SEL_W-1:0] run_sel [6];
    logic [31:0]      run_exp [6];

    initial begin
        checks   = 0;
        failures = 0;
        src_data = {32'h400, 32'h300, 32'h200, 32'h100, 32'h4};
        run_sel  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        run_exp  = '{32'h4, 32'h100, 32'h200, 32'h300, 32'h400, 32'h400};

        // Reset held two cycles
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("reset_pc", pc_out, 32'h0);
        checkOutput("reset_epc", epc, 32'h0);
        checkOutput("reset_inh", {31'b0, in_handler}, 32'h0);
        checkOutput("reset_ack", {31'b0, int_ack}, 32'h0);

        // Free-run through every select including the clamp case
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, run_sel[i], 0, 0);
            checkOutput($sformatf("run_sel%0d", run_sel[i]), pc_out, run_exp[i]);
        end

        // Interrupt entry from RUN with branch target selected
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("entry_pc", pc_out, HPC);
        checkOutput("entry_epc", epc, 32'h100);
        checkOutput("entry_inh", {31'b0, in_handler}, 32'h1);
        checkOutput("entry_ack", {31'b0, int_ack}, 32'h1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("entry_ack_drop", {31'b0, int_ack}, 32'h0);
        checkOutput("handler_pc", pc_out, 32'h4);
        checkOutput("handler_inh", {31'b0, in_handler}, 32'h1);

        // Nested request in handler, then ERET, then deferred entry
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("nested_inh", {31'b0, in_handler}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("eret_pc", pc_out, 32'h100);
        checkOutput("eret_inh", {31'b0, in_handler}, 32'h0);
        src_data[31:0] = 32'h104;
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("deferred_pc", pc_out, HPC);
        checkOutput("deferred_epc", epc, 32'h104);
        checkOutput("deferred_ack", {31'b0, int_ack}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("eret2_pc", pc_out, 32'h104);
        applyStimulus(0, 0, 2, 0, 0);
        checkOutput("no_spurious_pc", pc_out, 32'h200);
        checkOutput("no_spurious_inh", {31'b0, in_handler}, 32'h0);

        // Stall for three cycles with a request pulsed mid-stall
        applyStimulus(0, 1, 3, 0, 0);
        checkOutput("stall1_pc", pc_out, 32'h200);
        applyStimulus(0, 1, 3, 1, 0);
        checkOutput("stall2_pc", pc_out, 32'h200);
        checkOutput("stall2_inh", {31'b0, in_handler}, 32'h0);
        applyStimulus(0, 1, 3, 0, 0);
        checkOutput("stall3_pc", pc_out, 32'h200);
        checkOutput("stall3_epc", epc, 32'h104);
        checkOutput("stall3_ack", {31'b0, int_ack}, 32'h0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("unstall_pc", pc_out, HPC);
        checkOutput("unstall_epc", epc, 32'h100);
        checkOutput("unstall_ack", {31'b0, int_ack}, 32'h1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("eret3_pc", pc_out, 32'h100);

        // ERET while in RUN is ignored
        applyStimulus(0, 0, 2, 0, 1);
        checkOutput("eret_run_pc", pc_out, 32'h200);
        checkOutput("eret_run_epc", epc, 32'h100);
        checkOutput("eret_run_inh", {31'b0, in_handler}, 32'h0);

        // Reset while in handler with a request pending
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pre_rst_epc", epc, 32'h104);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("rst_h_pc", pc_out, 32'h0);
        checkOutput("rst_h_epc", epc, 32'h0);
        checkOutput("rst_h_inh", {31'b0, in_handler}, 32'h0);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("post_rst_pc", pc_out, 32'h100);
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("post_rst_inh", {31'b0, in_handler}, 32'h0);

        // Simultaneous ERET and request in handler: return first, then enter
        applyStimulus(0, 0, 2, 1, 0);
        checkOutput("sim_entry_epc", epc, 32'h200);
        applyStimulus(0, 0, 2, 1, 1);
        checkOutput("sim_eret_pc", pc_out, 32'h200);
        checkOutput("sim_eret_inh", {31'b0, in_handler}, 32'h0);
        applyStimulus(0, 0, 3, 0, 0);
        checkOutput("sim_take_pc", pc_out, HPC);
        checkOutput("sim_take_epc", epc, 32'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
Name: pc_next_unit

Overview:
- Parametrised next-PC selector and program-counter register for the pipelined MIPS fetch stage.
- Selects one of NUM_SRC candidate addresses: fall-through, branch, jump, jump-register, and so on.
- Owns the PC register, the EPC register, a pending-interrupt latch and a two-state handler state machine.
- Supports ERET return and fetch stall; nested interrupts are deferred, not dropped.

Parameters:
- WIDTH, 32, address width in bits.
- NUM_SRC, 5, number of candidate next-PC inputs (minimum 2).
- SEL_W, 3, select width; must satisfy 2**SEL_W >= NUM_SRC.
- RESET_PC, 32'h0000_0000, PC value after reset.
- HANDLER_PC, 32'h8000_0180, interrupt vector loaded on interrupt entry.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the PC; no PC, EPC or state update.
- src_data  in  NUM_SRC*WIDTH  candidate addresses, packed; slice i is source i; slice 0 is fall-through (PC+4).
- sel  in  SEL_W  source select.
- int_req  in  1  external interrupt request, level or pulse.
- eret  in  1  return-from-exception request.
- pc_out  out  WIDTH  current PC (registered).
- epc  out  WIDTH  saved return address (registered).
- in_handler  out  1  high while in HANDLER state.
- int_ack  out  1  one-cycle pulse on the cycle after interrupt entry.

Behaviour:
- Reset (synchronous, active-high; clk and rst as named above):
  - pc_out = RESET_PC, epc = 0, in_handler = 0, int_ack = 0.
  - Pending latch cleared, state = RUN.
  - Reset mid-handler abandons the handler and the pending interrupt.
- Mux (combinational): mux_pc = src_data slice sel when sel < NUM_SRC; otherwise slice NUM_SRC-1 (clamp).
- Pending latch:
  - Set on any cycle with int_req = 1.
  - Cleared only on the cycle an interrupt is taken.
  - A request arriving on the take cycle itself stays set and is served after the next ERET.
- States: RUN, HANDLER. in_handler = (state == HANDLER).
- Per-edge priority, when rst = 0:
  1. stall = 1: PC, EPC and state hold. Pending still latches int_req. int_ack = 0.
  2. RUN and (pending or int_req): take the interrupt.
     - epc <= mux_pc, so no instruction is lost.
     - pc_out <= HANDLER_PC.
     - state <= HANDLER, pending cleared.
     - int_ack = 1 for exactly the following cycle.
  3. HANDLER and eret: pc_out <= epc, state <= RUN. The interrupt is not taken this edge even if pending.
  4. Otherwise: pc_out <= mux_pc.
- int_req in HANDLER: latched only. Taken at the first non-stalled RUN edge, i.e. at least one cycle after the ERET edge. epc then = mux_pc of that cycle.
- eret in RUN: ignored; normal select applies.
- Simultaneous eret and int_req in HANDLER: ERET completes first, the interrupt is taken on the next non-stalled edge.
- Latency:
  - Select to pc_out: 1 cycle.
  - int_req to pc_out = HANDLER_PC: 1 cycle when unstalled in RUN.
- Width rules:
  - All addresses are WIDTH bits, no arithmetic inside the block, no alignment check.
  - epc is written only on interrupt entry.

Decomposition:
- Package pc_next_pkg:
  - state enum {RUN, HANDLER}.
  - Default HANDLER_PC and RESET_PC constants.
  - Source index constants: SRC_SEQ = 0, SRC_BR = 1, SRC_J = 2, SRC_JR = 3, SRC_ALT = 4.
- One sub-module pc_src_mux: combinational NUM_SRC:1 mux with the out-of-range clamp, parametrised by WIDTH, NUM_SRC and SEL_W.

Test Plan:
- Reset then free-run: rst held 2 cycles, sources = {0x4, 0x100, 0x200, 0x300, 0x400}, sel cycles 0 through 4 and 7 -> pc_out = 0x0, then 0x4, 0x100, 0x200, 0x300, 0x400, 0x400 (clamp), one cycle after each sel.
- Interrupt entry: RUN, sel = 1 (src1 = 0x100), int_req pulse -> next edge pc_out = 0x8000_0180, epc = 0x100, in_handler = 1, int_ack high exactly 1 cycle.
- Nested plus ERET: in HANDLER, int_req pulse while epc = 0x100, then eret -> pc_out = 0x100, in_handler = 0; next edge with sel = 0 (src0 = 0x104) -> pc_out = 0x8000_0180, epc = 0x104.
- Stall: stall = 1 for 3 cycles with int_req pulsed during the stall -> pc_out and epc unchanged throughout; first unstalled edge takes the interrupt.
- ERET in RUN: eret = 1, sel = 2 (src2 = 0x200) -> pc_out = 0x200, epc unchanged, state stays RUN.
- Reset in handler: in HANDLER with pending set, rst = 1 for 1 cycle -> pc_out = 0x0, epc = 0, in_handler = 0; no interrupt taken after reset without a new int_req.
